// File: rtl/status_leds_pwm_n.sv
// status_leds_pwm_n: multi-channel status LED PWM driver with steady, activity-decay, blink and off modes
module status_leds_pwm_n #(
   parameter int CHANNELS   = 4,
   parameter int LEVEL_BITS = 6,
   parameter int PRESCALE   = 64,
   parameter int DECAY_DIV  = 4,
   parameter int BLINK_DIV  = 32
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic [CHANNELS*LEVEL_BITS-1:0] level,
   input  logic [CHANNELS*2-1:0]          mode,
   input  logic [CHANNELS-1:0]            activity,
   output logic [CHANNELS-1:0]            leds_out
);
   localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
   localparam int DW = DECAY_DIV > 1 ? $clog2(DECAY_DIV) : 1;
   localparam int BW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
   localparam logic [DW-1:0] DEC_LAST = DW'(DECAY_DIV - 1);
   localparam logic [BW-1:0] BLK_LAST = BW'(BLINK_DIV - 1);
   localparam logic [LEVEL_BITS-1:0] MAX = '1;
   logic [PW-1:0]         r_pre;
   logic [LEVEL_BITS-1:0] r_cnt;
   logic [DW-1:0]         r_dec;
   logic [BW-1:0]         r_blk;
   logic                  r_phase;
   logic                  w_tick, w_wrap, w_decay_step, w_blink_flip;
   assign w_tick       = r_pre == PRE_LAST;
   assign w_wrap       = w_tick && r_cnt == MAX;
   assign w_decay_step = w_wrap && r_dec == DEC_LAST;
   assign w_blink_flip = w_wrap && r_blk == BLK_LAST;
   // shared timebase: prescaler, PWM counter, period counters and blink phase (phase 0 = on)
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pre   <= '0;
         r_cnt   <= '0;
         r_dec   <= '0;
         r_blk   <= '0;
         r_phase <= 1'b0;
      end else begin
         r_pre <= w_tick ? '0 : r_pre + 1'b1;
         if (w_tick) r_cnt <= r_cnt + 1'b1;
         if (w_wrap) begin
            r_dec <= r_dec == DEC_LAST ? '0 : r_dec + 1'b1;
            r_blk <= r_blk == BLK_LAST ? '0 : r_blk + 1'b1;
         end
         if (w_blink_flip) r_phase <= ~r_phase;
      end
   end
   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      logic [LEVEL_BITS-1:0] w_lvl, w_req, r_act, r_duty;
      logic [1:0]            w_mode;
      logic                  r_led;
      assign w_lvl  = level[i*LEVEL_BITS +: LEVEL_BITS];
      assign w_mode = mode[2*i +: 2];
      assign w_req  = w_mode == 2'b00 ? w_lvl :
                      w_mode == 2'b01 ? r_act :
                      w_mode == 2'b10 ? (r_phase ? '0 : w_lvl) : '0;
      assign leds_out[i] = r_led;
      // activity load beats decay; duty only changes at the period wrap so pulses are never cut
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            r_act  <= '0;
            r_duty <= '0;
            r_led  <= 1'b0;
         end else begin
            if (activity[i]) r_act <= w_lvl;
            else if (w_decay_step && r_act != '0) r_act <= r_act - 1'b1;
            if (w_wrap) r_duty <= w_req;
            r_led <= (r_duty == MAX) | (r_cnt < r_duty);
         end
      end
   end
endmodule

// File: tb/tb_status_leds_pwm_n.sv
// tb_status_leds_pwm_n: scoreboard bench for status_leds_pwm_n with a 32-clk PWM period
module tb_status_leds_pwm_n;
   logic       clk = 1'b0;
   logic       reset_n = 1'b1;
   logic [3:0] lv0, lv1;
   logic [1:0] md0, md1;
   logic [1:0] act;
   logic [7:0] level;
   logic [3:0] mode;
   logic [1:0] leds_out;
   logic [1:0] q[$];
   int total = 0;
   int bad = 0;
   assign level = {lv1, lv0};
   assign mode  = {md1, md0};
   status_leds_pwm_n #(.CHANNELS(2), .LEVEL_BITS(4), .PRESCALE(2), .DECAY_DIV(1), .BLINK_DIV(2)) dut (
      .clk(clk), .reset_n(reset_n), .level(level), .mode(mode), .activity(act), .leds_out(leds_out)
   );
   initial forever #5 clk = ~clk;
   function automatic logic hi_bit(input int d, input int m);
      return (d == 15) || (m <= 2 * d);
   endfunction
   task automatic run_steps(input int d0, input int d1, input int lo, input int hi);
      for (int m = lo; m <= hi; m++) begin
         @(posedge clk);
         #1;
         q.push_back({hi_bit(d1, m), hi_bit(d0, m)});
      end
   endtask
   task automatic run_period(input int d0, input int d1);
      run_steps(d0, d1, 1, 32);
   endtask
   task automatic chk_dark(input string name);
      total++;
      if (leds_out !== 2'b00) begin
         bad++;
         $display("FAIL %s t=%0t got=%b exp=00", name, $time, leds_out);
      end
   endtask
   initial begin
      logic [1:0] e;
      forever begin
         @(negedge clk);
         if (q.size() != 0) begin
            e = q.pop_front();
            total++;
            if (leds_out !== e) begin
               bad++;
               $display("FAIL leds t=%0t got=%b exp=%b", $time, leds_out, e);
            end
         end
      end
   end
   initial begin
      lv0 = 4'd9; lv1 = 4'd5; md0 = 2'b11; md1 = 2'b10; act = 2'b11;
      #2 reset_n = 1'b0;
      #1 chk_dark("reset_async");
      #19;
      chk_dark("reset_held");
      lv0 = 4'd4; lv1 = 4'd15; md0 = 2'b00; md1 = 2'b00; act = 2'b00;
      reset_n = 1'b1;
      run_period(0, 0);
      run_period(4, 15);
      lv0 = 4'd0;
      run_period(4, 15);
      run_period(0, 15);
      lv0 = 4'd4;
      run_period(0, 15);
      run_steps(4, 15, 1, 5);
      lv0 = 4'd12;
      run_steps(4, 15, 6, 32);
      run_period(12, 15);
      md0 = 2'b01; lv0 = 4'd3;
      run_steps(12, 15, 1, 10);
      act = 2'b01;
      run_steps(12, 15, 11, 11);
      act = 2'b00;
      run_steps(12, 15, 12, 32);
      run_period(3, 15);
      run_steps(2, 15, 1, 31);
      act = 2'b01;
      run_steps(2, 15, 32, 32);
      act = 2'b00;
      run_period(1, 15);
      run_period(3, 15);
      run_period(2, 15);
      md0 = 2'b10; lv0 = 4'd8; md1 = 2'b11;
      run_period(1, 15);
      run_period(8, 0);
      run_period(0, 0);
      run_period(0, 0);
      run_period(8, 0);
      run_period(8, 0);
      run_period(0, 0);
      run_period(0, 0);
      run_steps(8, 0, 1, 3);
      @(negedge clk);
      #1 reset_n = 1'b0;
      #1 chk_dark("reset_mid_period");
      md0 = 2'b00; md1 = 2'b00; lv0 = 4'd15; lv1 = 4'd15;
      @(posedge clk);
      #2 chk_dark("reset_over_edge");
      reset_n = 1'b1;
      run_period(0, 0);
      run_period(15, 15);
      @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
